// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative DES core, one Feistel round per clock
// Decrypts by default (right-rotating schedule, K16 first); MODE_DECRYPT=0 encrypts.
module S_Box_1 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [255:0] T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  assign out = T[8'd255 - {in[5], in[0], in[4:1], 2'b00} -: 4];
endmodule

module S_Box_2 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [255:0] T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  assign out = T[8'd255 - {in[5], in[0], in[4:1], 2'b00} -: 4];
endmodule

module S_Box_3 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [255:0] T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  assign out = T[8'd255 - {in[5], in[0], in[4:1], 2'b00} -: 4];
endmodule

module S_Box_4 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [255:0] T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  assign out = T[8'd255 - {in[5], in[0], in[4:1], 2'b00} -: 4];
endmodule

module S_Box_5 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [255:0] T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  assign out = T[8'd255 - {in[5], in[0], in[4:1], 2'b00} -: 4];
endmodule

module S_Box_6 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [255:0] T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  assign out = T[8'd255 - {in[5], in[0], in[4:1], 2'b00} -: 4];
endmodule

module S_Box_7 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [255:0] T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  assign out = T[8'd255 - {in[5], in[0], in[4:1], 2'b00} -: 4];
endmodule

module S_Box_8 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [255:0] T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
  assign out = T[8'd255 - {in[5], in[0], in[4:1], 2'b00} -: 4];
endmodule

module des_decrypt_core #(
  parameter logic MODE_DECRYPT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipher_in,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain_out,
  output logic        busy
);
  // Tables hold 1-based DES bit numbers; DES bit n sits at vector bit (width - n).
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};

  function automatic logic [63:0] ip(input logic [63:0] x);
    ip = '0;
    for (int i = 0; i < 64; i++) ip[63-i] = x[64-IP_T[i]];
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    fp = '0;
    for (int i = 0; i < 64; i++) fp[63-i] = x[64-FP_T[i]];
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    pc1 = '0;
    for (int i = 0; i < 56; i++) pc1[55-i] = x[64-PC1_T[i]];
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    pc2 = '0;
    for (int i = 0; i < 48; i++) pc2[47-i] = x[56-PC2_T[i]];
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    e_exp = '0;
    for (int i = 0; i < 48; i++) e_exp[47-i] = x[32-E_T[i]];
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    p_perm = '0;
    for (int i = 0; i < 32; i++) p_perm[31-i] = x[32-P_T[i]];
  endfunction

  // Left rotation moves bits toward DES bit 1, i.e. toward the MSB.
  function automatic logic [27:0] rot(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rot = MODE_DECRYPT ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2'd2:    rot = MODE_DECRYPT ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: rot = x;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic [31:0] l_q, r_q, sbox_out, f_out;
  logic [27:0] c_q, d_q, c_nx, d_nx;
  logic [3:0]  cnt;
  logic [1:0]  shift;
  logic [47:0] subkey, sbox_in;

  always_comb begin
    shift = 2'd2;
    if (cnt == 4'd0)                                  shift = MODE_DECRYPT ? 2'd0 : 2'd1;
    else if (cnt == 4'd1 || cnt == 4'd8 || cnt == 4'd15) shift = 2'd1;
  end

  assign c_nx    = rot(c_q, shift);
  assign d_nx    = rot(d_q, shift);
  assign subkey  = pc2({c_nx, d_nx});
  assign sbox_in = e_exp(r_q) ^ subkey;

  S_Box_1 u_s1 (.in(sbox_in[47:42]), .out(sbox_out[31:28]));
  S_Box_2 u_s2 (.in(sbox_in[41:36]), .out(sbox_out[27:24]));
  S_Box_3 u_s3 (.in(sbox_in[35:30]), .out(sbox_out[23:20]));
  S_Box_4 u_s4 (.in(sbox_in[29:24]), .out(sbox_out[19:16]));
  S_Box_5 u_s5 (.in(sbox_in[23:18]), .out(sbox_out[15:12]));
  S_Box_6 u_s6 (.in(sbox_in[17:12]), .out(sbox_out[11:8]));
  S_Box_7 u_s7 (.in(sbox_in[11:6]),  .out(sbox_out[7:4]));
  S_Box_8 u_s8 (.in(sbox_in[5:0]),   .out(sbox_out[3:0]));

  assign f_out = p_perm(sbox_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (cnt == 4'd15) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q <= '0; r_q <= '0; c_q <= '0; d_q <= '0;
      cnt <= '0; plain_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {l_q, r_q} <= ip(cipher_in);
          {c_q, d_q} <= pc1(key_in);
          cnt        <= 4'd0;
        end
        ROUND: begin
          c_q <= c_nx;
          d_q <= d_nx;
          l_q <= r_q;
          r_q <= l_q ^ f_out;
          cnt <= cnt + 4'd1;
          // Final round output is taken with the halves swapped.
          if (cnt == 4'd15) plain_out <= fp({l_q ^ f_out, r_q});
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_decrypt_core.sv
// tb/tb_des_decrypt_core.sv - randomized DES decrypt/encrypt bench with a software DES model
module tb_des_decrypt_core;
  logic clk, rst_n;
  logic d_iv, d_irdy, d_ov, d_ordy, d_busy;
  logic [63:0] d_cin, d_key, d_pout;
  logic e_iv, e_irdy, e_ov, e_ordy, e_busy;
  logic [63:0] e_cin, e_key, e_pout;
  int n_tests = 0, n_fail = 0;

  des_decrypt_core #(.MODE_DECRYPT(1'b1)) u_dec (
    .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_irdy), .cipher_in(d_cin),
    .key_in(d_key), .out_valid(d_ov), .out_ready(d_ordy), .plain_out(d_pout), .busy(d_busy));
  des_decrypt_core #(.MODE_DECRYPT(1'b0)) u_enc (
    .clk(clk), .rst_n(rst_n), .in_valid(e_iv), .in_ready(e_irdy), .cipher_in(e_cin),
    .key_in(e_key), .out_valid(e_ov), .out_ready(e_ordy), .plain_out(e_pout), .busy(e_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ip_q[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                   64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int fp_q[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                   37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                   34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int pc1_q[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_q[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int e_q[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int p_q[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,
                   19,13,30,6,22,11,4,25};
  int shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [255:0] sb [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Output collects table-selected bits MSB-first; result is right-aligned.
  function automatic logic [63:0] perm(input logic [63:0] x, input int w, input int t[$]);
    logic [63:0] r = '0;
    foreach (t[i]) r = {r[62:0], x[w - t[i]]};
    return r;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] tmp;
    logic [47:0] x;
    logic [31:0] s = '0;
    logic [5:0]  six;
    int idx;
    tmp = perm({32'b0, r}, 32, e_q);
    x = tmp[47:0] ^ k;
    for (int j = 0; j < 8; j++) begin
      six = x[47-6*j -: 6];
      idx = 16 * {six[5], six[0]} + int'(six[4:1]);
      s = {s[27:0], sb[j][255-4*idx -: 4]};
    end
    tmp = perm({32'b0, s}, 32, p_q);
    return tmp[31:0];
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input bit dec);
    logic [63:0] tmp;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, r, t;
    tmp = perm(key, 64, pc1_q);
    c = tmp[55:28];
    d = tmp[27:0];
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < shifts[k]; n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      tmp = perm({8'b0, c, d}, 56, pc2_q);
      ks[k] = tmp[47:0];
    end
    tmp = perm(blk, 64, ip_q);
    l = tmp[63:32];
    r = tmp[31:0];
    for (int k = 0; k < 16; k++) begin
      t = r;
      r = l ^ feistel(r, ks[dec ? 15 - k : k]);
      l = t;
    end
    return perm({r, l}, 64, fp_q);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One block through either instance; inputs are scrambled while rounds run.
  task automatic xfer(input bit enc, input logic [63:0] key, input logic [63:0] blk, input bit hold,
                      output logic [63:0] res, output int lat);
    int g = 0;
    @(negedge clk);
    if (enc) begin e_cin = blk; e_key = key; e_iv = 1'b1; e_ordy = hold; end
    else     begin d_cin = blk; d_key = key; d_iv = 1'b1; d_ordy = hold; end
    while (!(enc ? e_irdy : d_irdy) && g < 40) begin @(negedge clk); g++; end
    check("accept_wait", 64'(g < 40), 64'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (enc) begin e_iv = 1'b0; e_cin = {$urandom, $urandom}; e_key = {$urandom, $urandom}; end
      else     begin d_iv = 1'b0; d_cin = {$urandom, $urandom}; d_key = {$urandom, $urandom}; end
      if (enc ? e_ov : d_ov) break;
      @(posedge clk);
      lat++;
    end while (lat < 40);
    res = enc ? e_pout : d_pout;
    if (!hold) begin
      if (enc) e_ordy = 1'b1; else d_ordy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (enc) e_ordy = 1'b0; else d_ordy = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] res, ct, k, b, held;
    int lat;
    bit bad;
    rst_n = 1'b0;
    d_iv = 0; d_ordy = 0; d_cin = '0; d_key = '0;
    e_iv = 0; e_ordy = 0; e_cin = '0; e_key = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(d_irdy), 64'd1);
    check("rst_out_valid", 64'(d_ov), 64'd0);
    check("rst_plain_out", d_pout, 64'd0);
    check("rst_busy", 64'(d_busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(d_irdy), 64'd1);

    xfer(1'b0, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0, res, lat);
    check("fips_dec", res, 64'h0123456789ABCDEF);
    check("fips_latency", 64'(lat), 64'd16);

    // Back-to-back with in_valid held, plus 10 cycles of output backpressure.
    @(negedge clk);
    d_cin = 64'h8CA64DE9C1B123A7; d_key = 64'h0; d_iv = 1'b1; d_ordy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d_cin = 64'h7359B2163E4EDC58; d_key = 64'hFFFFFFFFFFFFFFFF;
    check("round_busy", 64'(d_busy), 64'd1);
    bad = 0; lat = 0;
    while (!d_ov && lat < 40) begin
      if (d_irdy) bad = 1;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (d_irdy) bad = 1;
    check("b2b_in_ready_low", 64'(bad), 64'd0);
    check("b2b_latency", 64'(lat), 64'd16);
    check("zero_key_dec", d_pout, 64'h0);
    held = d_pout;
    bad = 0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (d_pout !== held || d_ov !== 1'b1 || d_irdy !== 1'b0 || d_busy !== 1'b0) bad = 1;
    end
    check("backpressure_hold", 64'(bad), 64'd0);
    d_ordy = 1'b1;
    @(posedge clk); @(negedge clk);
    d_ordy = 1'b0;
    check("drain_out_valid", 64'(d_ov), 64'd0);
    check("drain_in_ready", 64'(d_irdy), 64'd1);
    @(posedge clk); @(negedge clk);
    d_iv = 1'b0;
    lat = 0;
    while (!d_ov && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    check("ones_latency", 64'(lat), 64'd16);
    check("ones_key_dec", d_pout, 64'hFFFFFFFFFFFFFFFF);
    d_ordy = 1'b1;
    @(posedge clk); @(negedge clk);
    d_ordy = 1'b0;

    // Reset during round 7 discards the block.
    d_cin = 64'h85E813540F0AB405; d_key = 64'h133457799BBCDFF1; d_iv = 1'b1;
    @(posedge clk);
    @(negedge clk); d_iv = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(d_ov), 64'd0);
    check("midrst_busy", 64'(d_busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(d_irdy), 64'd1);
    check("midrst_out_valid2", 64'(d_ov), 64'd0);
    xfer(1'b0, 64'h0E329232EA6D0D73, 64'h0, 1'b0, res, lat);
    check("after_rst_dec", res, 64'h8787878787878787);

    xfer(1'b1, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, res, lat);
    check("fips_enc", res, 64'h85E813540F0AB405);

    // Random loopback with out_ready held high throughout.
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom};
      b = {$urandom, $urandom};
      xfer(1'b1, k, b, 1'b1, ct, lat);
      check("rand_enc", ct, des_ref(k, b, 1'b0));
      xfer(1'b0, k, ct, 1'b1, res, lat);
      check("rand_loopback", res, b);
      check("rand_latency", 64'(lat), 64'd16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
